riscv_trace_buffer: RTL and testbench
=====================================

Name: riscv_trace_buffer

Overview:
- Parametrised commit/memory event capture block for the RISC-V pipeline.
- Synthesisable successor to the bench-side register/memory print monitor: sits beside the core on the tb_* debug taps.
- Packs each cycle's register-write and memory-access activity, plus PC and a cycle timestamp, into one entry in a DEPTH-deep FIFO.
- Benches or on-chip debug logic drain the FIFO over a valid/ready port. Capture window is armed, stopped, and bounded by a cycle budget.

Parameters:
- PC_W, 9, PC width
- REG_ADDR_W, 5, register index width
- MEM_ADDR_W, 9, data-memory address width
- DATA_W, 32, register/memory data width
- DEPTH, 16, FIFO entries; power of two, ≥2
- TS_W, 16, timestamp width
- STOP_CYCLES, 50, capture-window length in cycles; 0 = unbounded
- OVERWRITE, 0, full policy: 0 = drop newest, 1 = discard oldest

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- arm  in  1  start/restart capture
- stop  in  1  end capture
- tb_PC  in  PC_W  PC of the reporting instruction
- tb_reg_write  in  1  register write this cycle
- tb_reg_addr  in  REG_ADDR_W  destination register
- tb_reg_write_data  in  DATA_W  value written
- tb_mem_write  in  1  memory write strobe
- tb_mem_read  in  1  memory read strobe
- tb_mem_addr  in  MEM_ADDR_W  memory address
- tb_mem_write_data  in  DATA_W  store data
- tb_mem_read_data  in  DATA_W  load data
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_entry  out  ENTRY_W  packed head entry (trace_entry_t)
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one drop/overwrite since arm
- drop_cnt  out  8  saturating count of lost entries
- running  out  1  FSM in RUN
- done  out  1  FSM in DONE

Behaviour:
- Reset (reset low, async):
  - FSM = IDLE.
  - FIFO empty; out_valid = 0; level = 0.
  - overflow = 0, drop_cnt = 0, timestamp = 0.
  - out_entry = 0; running = 0; done = 0.
  - Reset mid-capture discards all stored entries.
- FSM:
  - IDLE → RUN on arm.
  - RUN → DONE on stop, or when STOP_CYCLES ≠ 0 and timestamp == STOP_CYCLES−1.
  - DONE → RUN on arm.
  - arm and stop asserted together: stop wins. arm while in RUN is ignored.
  - Entering RUN clears timestamp, overflow and drop_cnt. FIFO contents are retained.
- Timestamp: increments by 1 every RUN cycle and holds otherwise. Wraps modulo 2^TS_W.
- Event qualification: an event cycle is RUN && (tb_reg_write | tb_mem_write | tb_mem_read). The cycle in which the FSM leaves RUN still captures.
- Entry fields: ts, pc, reg_v, reg_addr, reg_data, mem_kind, mem_addr, mem_data.
  - mem_kind: 00 none, 01 read, 10 write, 11 conflict (both strobes high).
  - mem_data: write data for kind 10 or 11, read data for kind 01, 0 for kind 00.
  - Register fields are zeroed when reg_v = 0.
- FIFO is first-word-fall-through:
  - A push is visible on out_valid/out_entry in the next cycle (latency 1).
  - A pop happens when out_valid && out_ready.
- Full with a push and no pop:
  - OVERWRITE=0: new entry dropped.
  - OVERWRITE=1: head discarded, new entry appended, level stays DEPTH.
  - In both cases drop_cnt increments (saturating at 255) and overflow is set.
- Full with push and pop in the same cycle: both succeed, no drop.
- Empty with push and out_ready high: no bypass; the entry appears the next cycle.
- Pointers wrap modulo DEPTH. level runs 0..DEPTH.

Optional Feature:
- Macro: RISCV_TRACE_FILTER_EN.
- Defined:
  - Adds ports filt_lo and filt_hi (in, MEM_ADDR_W each).
  - Memory events are captured only when filt_lo ≤ tb_mem_addr ≤ filt_hi, unsigned comparison.
  - Outside the window, mem_kind is forced to 00. The entry is still pushed if tb_reg_write is high, otherwise nothing is pushed.
  - filt_lo > filt_hi filters out all memory events.
- Undefined: the ports are absent and every memory event is captured.

Decomposition:
- Package riscv_trace_pkg holds:
  - mem_kind_e
  - trace_state_e (IDLE/RUN/DONE)
  - trace_entry_t, a parametrised-width packed struct with an ENTRY_W helper function
  - the drop_cnt width constant
- One sub-module, trace_fifo: DEPTH/width parametrised FWFT FIFO with overwrite mode, level, and push/pop/full/empty.
- The top level holds the FSM, timestamp, entry packing and optional filter.

Test Plan:
- Reset, arm, then one reg write x5 = 0x0000002A at PC 0x010 → one cycle later out_valid = 1, entry ts = 0, reg_v = 1, reg_addr = 5, mem_kind = 00.
- tb_mem_write and tb_mem_read both high, addr 9'd20, wdata 0xDEADBEEF → mem_kind = 11, mem_data = 0xDEADBEEF.
- DEPTH=16, out_ready = 0, 20 events:
  - OVERWRITE=0: level = 16, drop_cnt = 4, head ts = 0.
  - OVERWRITE=1: level = 16, drop_cnt = 4, head ts = 4.
- FIFO full, push and pop in the same cycle → level stays 16, drop_cnt unchanged.
- STOP_CYCLES = 50, arm, continuous events:
  - done rises after the 50th RUN cycle; last entry ts = 49; no entries after.
  - Re-arm → ts restarts at 0.
- Reset pulsed low mid-capture with 7 entries stored → out_valid = 0, level = 0, FSM IDLE immediately, without waiting for a clock edge.
- With RISCV_TRACE_FILTER_EN, filt_lo = 16, filt_hi = 31, mem reads at addresses 8, 16, 31, 32 → exactly 2 entries (16 and 31).

Source files
------------

// File: rtl/riscv_trace_buffer_pkg.sv
// riscv_trace_pkg: shared types and constants for the RISC-V trace buffer.
// Holds the memory-access kind encoding, the capture FSM states, the entry
// layout (at default widths) and a helper that sizes a packed entry.
package riscv_trace_pkg;

    // Width of the saturating lost-entry counter.
    localparam int DROP_CNT_W = 8;

    // Default field widths; the top level derives its own entry type from
    // its parameters using the same field order.
    localparam int DEF_TS_W       = 16;
    localparam int DEF_PC_W       = 9;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_MEM_ADDR_W = 9;
    localparam int DEF_DATA_W     = 32;

    // Encoding is {write, read}, so a conflict is both strobes at once.
    typedef enum logic [1:0] {
        MEM_NONE     = 2'b00,
        MEM_READ     = 2'b01,
        MEM_WRITE    = 2'b10,
        MEM_CONFLICT = 2'b11
    } mem_kind_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } trace_state_e;

    // Entry layout, most significant field first.
    typedef struct packed {
        logic [DEF_TS_W-1:0]       ts;
        logic [DEF_PC_W-1:0]       pc;
        logic                      reg_v;
        logic [DEF_REG_ADDR_W-1:0] reg_addr;
        logic [DEF_DATA_W-1:0]     reg_data;
        mem_kind_e                 mem_kind;
        logic [DEF_MEM_ADDR_W-1:0] mem_addr;
        logic [DEF_DATA_W-1:0]     mem_data;
    } trace_entry_t;

    // Packed entry width for an arbitrary set of field widths.
    function automatic int entry_w(input int ts_w, input int pc_w,
                                   input int reg_addr_w, input int mem_addr_w,
                                   input int data_w);
        return ts_w + pc_w + 1 + reg_addr_w + data_w + 2 + mem_addr_w + data_w;
    endfunction

endpackage

// File: rtl/riscv_trace_buffer_fifo.sv
// trace_fifo: first-word-fall-through FIFO for packed trace entries.
// The head word is presented combinationally from storage; a write becomes
// visible one cycle later. When full, OVERWRITE=0 drops the incoming word,
// OVERWRITE=1 discards the head to make room. DEPTH must be a power of two.
module trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0,
    localparam int AW       = $clog2(DEPTH),
    localparam int LVL_W    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_count;

    logic w_pop;
    logic w_wr_en;
    logic w_rd_adv;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == LVL_W'(DEPTH));
    assign o_level = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // A pop only means something when there is a head word to take.
    assign w_pop    = i_pop && !o_empty;
    // Full without a pop: write only in overwrite mode, which also retires the head.
    assign w_wr_en  = i_push && (!o_full || w_pop || OVERWRITE);
    assign w_rd_adv = w_pop || (OVERWRITE && i_push && o_full);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_rd_adv})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; r_count gates every read, so stale words are never seen.
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: per-cycle commit/memory event capture for the RISC-V core.
// An IDLE/RUN/DONE window (armed, stopped, optionally bounded by STOP_CYCLES)
// packs register-write and memory activity, PC and a timestamp into entries
// held in a FWFT FIFO drained over out_valid/out_ready.
// Optional: define RISCV_TRACE_FILTER_EN to add the filt_lo/filt_hi memory
// address window; memory events outside it are not recorded.
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int PC_W        = 9,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_ADDR_W  = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter int STOP_CYCLES = 50,
    parameter bit OVERWRITE   = 1'b0,
    localparam int ENTRY_W    = entry_w(TS_W, PC_W, REG_ADDR_W, MEM_ADDR_W, DATA_W),
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  stop,
    input  logic [PC_W-1:0]       tb_PC,
    input  logic                  tb_reg_write,
    input  logic [REG_ADDR_W-1:0] tb_reg_addr,
    input  logic [DATA_W-1:0]     tb_reg_write_data,
    input  logic                  tb_mem_write,
    input  logic                  tb_mem_read,
    input  logic [MEM_ADDR_W-1:0] tb_mem_addr,
    input  logic [DATA_W-1:0]     tb_mem_write_data,
    input  logic [DATA_W-1:0]     tb_mem_read_data,
`ifdef RISCV_TRACE_FILTER_EN
    input  logic [MEM_ADDR_W-1:0] filt_lo,
    input  logic [MEM_ADDR_W-1:0] filt_hi,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ENTRY_W-1:0]    out_entry,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  running,
    output logic                  done
);

    // Entry layout matching trace_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [TS_W-1:0]       ts;
        logic [PC_W-1:0]       pc;
        logic                  reg_v;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     reg_data;
        mem_kind_e             mem_kind;
        logic [MEM_ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0]     mem_data;
    } entry_t;

    trace_state_e          r_state;
    logic [TS_W-1:0]       r_ts;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  r_running;
    logic                  r_done;

    logic                  w_in_window;
    mem_kind_e             w_kind;
    entry_t                w_entry;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_lost;
    logic                  w_window_end;
    logic [ENTRY_W-1:0]    w_head;
    logic [LVL_W-1:0]      w_level;

`ifdef RISCV_TRACE_FILTER_EN
    // Inclusive unsigned window; lo > hi naturally rejects every address.
    assign w_in_window = (tb_mem_addr >= filt_lo) && (tb_mem_addr <= filt_hi);
`else
    assign w_in_window = 1'b1;
`endif

    // Classify this cycle's memory access and pack the candidate entry.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_kind  = MEM_NONE;
        w_entry = '0;
        if (w_in_window) begin
            if (tb_mem_write && tb_mem_read) begin
                w_kind = MEM_CONFLICT;
            end else if (tb_mem_write) begin
                w_kind = MEM_WRITE;
            end else if (tb_mem_read) begin
                w_kind = MEM_READ;
            end
        end
        w_entry.ts       = r_ts;
        w_entry.pc       = tb_PC;
        w_entry.reg_v    = tb_reg_write;
        w_entry.mem_kind = w_kind;
        if (tb_reg_write) begin
            w_entry.reg_addr = tb_reg_addr;
            w_entry.reg_data = tb_reg_write_data;
        end
        // Address is only meaningful when an access was recorded.
        if (w_kind != MEM_NONE) begin
            w_entry.mem_addr = tb_mem_addr;
        end
        case (w_kind)
            MEM_WRITE, MEM_CONFLICT: w_entry.mem_data = tb_mem_write_data;
            MEM_READ:                w_entry.mem_data = tb_mem_read_data;
            default:                 w_entry.mem_data = '0;
        endcase
    end

    // Capture happens on every RUN cycle, including the one that leaves RUN.
    assign w_push       = (r_state == RUN) && (tb_reg_write || (w_kind != MEM_NONE));
    assign w_pop        = !w_empty && out_ready;
    // Full with no simultaneous pop loses one entry under either full policy.
    assign w_lost       = w_push && w_full && !w_pop;
    assign w_window_end = (STOP_CYCLES != 0) && (r_ts == TS_W'(STOP_CYCLES - 1));

    trace_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Capture-window FSM with timestamp, loss tracking and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ts       <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    // stop takes priority over a simultaneous arm.
                    if (arm && !stop) begin
                        r_state    <= RUN;
                        r_ts       <= '0;
                        r_overflow <= 1'b0;
                        r_drop_cnt <= '0;
                        r_running  <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                RUN: begin
                    r_ts <= r_ts + TS_W'(1);
                    if (w_lost) begin
                        r_overflow <= 1'b1;
                        if (r_drop_cnt != '1) begin
                            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                        end
                    end
                    if (stop || w_window_end) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = !w_empty;
    assign out_entry = w_head;
    assign level     = w_level;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
    assign running   = r_running;
    assign done      = r_done;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer: two instances (drop-newest and discard-oldest) share
// all stimulus except out_ready, and are compared every cycle against a
// queue-based reference model plus directed scenario checks.
// Define RISCV_TRACE_FILTER_EN to exercise the address filter as well.
module tb_riscv_trace_buffer;

    localparam int PC_W  = 9;
    localparam int RAW   = 5;
    localparam int MAW   = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
    localparam int STOP  = 50;
    localparam int EW    = TS_W + PC_W + 1 + RAW + DW + 2 + MAW + DW;
    localparam int LW    = $clog2(DEPTH) + 1;

    // Field positions inside a packed entry (most significant field is ts).
    localparam int MD_LSB = 0;
    localparam int MA_LSB = MD_LSB + DW;
    localparam int K_LSB  = MA_LSB + MAW;
    localparam int RD_LSB = K_LSB + 2;
    localparam int RA_LSB = RD_LSB + DW;
    localparam int RV_BIT = RA_LSB + RAW;
    localparam int PC_LSB = RV_BIT + 1;
    localparam int TS_LSB = PC_LSB + PC_W;

    typedef logic [EW-1:0] ent_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            arm = 1'b0;
    logic            stop = 1'b0;
    logic [PC_W-1:0] pc = '0;
    logic            rw = 1'b0;
    logic [RAW-1:0]  raddr = '0;
    logic [DW-1:0]   rdata = '0;
    logic            mw = 1'b0;
    logic            mr = 1'b0;
    logic [MAW-1:0]  maddr = '0;
    logic [DW-1:0]   wdata = '0;
    logic [DW-1:0]   rddata = '0;
    logic [MAW-1:0]  filt_lo = '0;
    logic [MAW-1:0]  filt_hi = '1;
    logic            ready0 = 1'b0;
    logic            ready1 = 1'b0;

    logic            o_valid_w [2];
    ent_t            o_entry_w [2];
    logic [LW-1:0]   o_level_w [2];
    logic            o_ovf_w   [2];
    logic [7:0]      o_drop_w  [2];
    logic            o_run_w   [2];
    logic            o_done_w  [2];

    // Reference model: 0 idle, 1 capturing, 2 finished.
    int   m_state [2];
    int   m_ts    [2];
    bit   m_ovf   [2];
    int   m_drops [2];
    ent_t m_q     [2][$];

    int n_total = 0;
    int n_bad   = 0;
    int last_ts = -1;

    always #5 clk = ~clk;

    riscv_trace_buffer #(
        .PC_W(PC_W), .REG_ADDR_W(RAW), .MEM_ADDR_W(MAW), .DATA_W(DW),
        .DEPTH(DEPTH), .TS_W(TS_W), .STOP_CYCLES(STOP), .OVERWRITE(1'b0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .tb_PC(pc),
        .tb_reg_write(rw), .tb_reg_addr(raddr), .tb_reg_write_data(rdata),
        .tb_mem_write(mw), .tb_mem_read(mr), .tb_mem_addr(maddr),
        .tb_mem_write_data(wdata), .tb_mem_read_data(rddata),
`ifdef RISCV_TRACE_FILTER_EN
        .filt_lo(filt_lo), .filt_hi(filt_hi),
`endif
        .out_valid(o_valid_w[0]), .out_ready(ready0), .out_entry(o_entry_w[0]),
        .level(o_level_w[0]), .overflow(o_ovf_w[0]), .drop_cnt(o_drop_w[0]),
        .running(o_run_w[0]), .done(o_done_w[0])
    );

    riscv_trace_buffer #(
        .PC_W(PC_W), .REG_ADDR_W(RAW), .MEM_ADDR_W(MAW), .DATA_W(DW),
        .DEPTH(DEPTH), .TS_W(TS_W), .STOP_CYCLES(STOP), .OVERWRITE(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .tb_PC(pc),
        .tb_reg_write(rw), .tb_reg_addr(raddr), .tb_reg_write_data(rdata),
        .tb_mem_write(mw), .tb_mem_read(mr), .tb_mem_addr(maddr),
        .tb_mem_write_data(wdata), .tb_mem_read_data(rddata),
`ifdef RISCV_TRACE_FILTER_EN
        .filt_lo(filt_lo), .filt_hi(filt_hi),
`endif
        .out_valid(o_valid_w[1]), .out_ready(ready1), .out_entry(o_entry_w[1]),
        .level(o_level_w[1]), .overflow(o_ovf_w[1]), .drop_cnt(o_drop_w[1]),
        .running(o_run_w[1]), .done(o_done_w[1])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int f_ts(input ent_t e);
        return int'(e[TS_LSB +: TS_W]);
    endfunction

    // mem_addr carries no information when no access was recorded.
    function automatic ent_t norm(input ent_t e);
        ent_t r = e;
        if (r[K_LSB +: 2] == 2'b00) r[MA_LSB +: MAW] = '0;
        return r;
    endfunction

    // Expected entry for the current inputs, built field by field from the capture rules.
    function automatic ent_t expected_entry(input int ts, output bit is_event);
        bit             in_win = 1'b1;
        logic [1:0]     kind;
        logic [DW-1:0]  md;
        logic [MAW-1:0] ma;
`ifdef RISCV_TRACE_FILTER_EN
        in_win = (maddr >= filt_lo) && (maddr <= filt_hi);
`endif
        kind = 2'd0;
        md   = '0;
        ma   = '0;
        if (in_win) begin
            if (mw && mr)  begin kind = 2'd3; md = wdata;  end
            else if (mw)   begin kind = 2'd2; md = wdata;  end
            else if (mr)   begin kind = 2'd1; md = rddata; end
        end
        if (kind != 2'd0) ma = maddr;
        is_event = rw || (kind != 2'd0);
        return {TS_W'(ts), pc, rw, rw ? raddr : RAW'(0), rw ? rdata : DW'(0), kind, ma, md};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_ts[k]    = 0;
            m_ovf[k]   = 1'b0;
            m_drops[k] = 0;
            m_q[k].delete();
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (!reset) return;
        for (int k = 0; k < 2; k++) begin
            bit   ev;
            bit   rdy  = (k == 0) ? ready0 : ready1;
            bit   full = (m_q[k].size() == DEPTH);
            bit   pop  = (m_q[k].size() > 0) && rdy;
            ent_t e    = expected_entry(m_ts[k], ev);
            if (pop) void'(m_q[k].pop_front());
            if (m_state[k] == 1 && ev) begin
                if (full && !pop) begin
                    m_ovf[k]   = 1'b1;
                    m_drops[k] = (m_drops[k] < 255) ? m_drops[k] + 1 : 255;
                    if (k == 1) begin
                        void'(m_q[k].pop_front());
                        m_q[k].push_back(e);
                    end
                end else begin
                    m_q[k].push_back(e);
                end
            end
            if (m_state[k] == 1) begin
                if (stop || (m_ts[k] == STOP - 1)) m_state[k] = 2;
                m_ts[k] = (m_ts[k] + 1) % (1 << TS_W);
            end else if (arm && !stop) begin
                m_state[k] = 1;
                m_ts[k]    = 0;
                m_ovf[k]   = 1'b0;
                m_drops[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int   n = m_q[k].size();
            ent_t exp_head = '0;
            if (n != 0) exp_head = norm(m_q[k][0]);
            check($sformatf("valid%0d", k), o_valid_w[k], n != 0);
            check($sformatf("level%0d", k), o_level_w[k], n);
            check($sformatf("entry%0d", k), norm(o_entry_w[k]), exp_head);
            check($sformatf("overflow%0d", k), o_ovf_w[k], m_ovf[k]);
            check($sformatf("drop_cnt%0d", k), o_drop_w[k], m_drops[k]);
            check($sformatf("running%0d", k), o_run_w[k], m_state[k] == 1);
            check($sformatf("done%0d", k), o_done_w[k], m_state[k] == 2);
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_events();
        rw = 1'b0; mw = 1'b0; mr = 1'b0; arm = 1'b0; stop = 1'b0;
    endtask

    // Empty both FIFOs, remembering the timestamp of the last DUT0 entry taken.
    task automatic drain();
        ready0 = 1'b1;
        ready1 = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (!o_valid_w[0] && !o_valid_w[1]) break;
            if (o_valid_w[0]) last_ts = f_ts(o_entry_w[0]);
            step();
        end
        ready0 = 1'b0;
        ready1 = 1'b0;
        check("drain_empty", {o_valid_w[0], o_valid_w[1]}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #2;
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) step();

        // First capture: one register write right after arming.
        arm = 1'b1; step(); arm = 1'b0;
        rw = 1'b1; raddr = 5'd5; rdata = 32'h0000_002A; pc = 9'h010;
        step();
        rw = 1'b0;
        check("first_valid", o_valid_w[0], 1'b1);
        check("first_ts", f_ts(o_entry_w[0]), 0);
        check("first_reg_v", o_entry_w[0][RV_BIT], 1'b1);
        check("first_reg_addr", o_entry_w[0][RA_LSB +: RAW], 5);
        check("first_kind", o_entry_w[0][K_LSB +: 2], 2'b00);

        // Simultaneous load and store strobes.
        mw = 1'b1; mr = 1'b1; maddr = 9'd20; wdata = 32'hDEAD_BEEF; rddata = 32'h1234_5678;
        step();
        mw = 1'b0; mr = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1; step(); ready0 = 1'b0; ready1 = 1'b0;
        check("conflict_kind", o_entry_w[0][K_LSB +: 2], 2'b11);
        check("conflict_data", o_entry_w[0][MD_LSB +: DW], 32'hDEAD_BEEF);
        check("conflict_addr", o_entry_w[0][MA_LSB +: MAW], 20);
        stop = 1'b1; step(); stop = 1'b0;
        drain();

        // 20 events into a 16-deep FIFO with nobody draining.
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rw = 1'b1; raddr = RAW'(i); rdata = $urandom; pc = PC_W'(i);
            step();
        end
        check("ovf_level0", o_level_w[0], 16);
        check("ovf_level1", o_level_w[1], 16);
        check("ovf_drops0", o_drop_w[0], 4);
        check("ovf_drops1", o_drop_w[1], 4);
        check("ovf_head_ts0", f_ts(o_entry_w[0]), 0);
        check("ovf_head_ts1", f_ts(o_entry_w[1]), 4);
        // Full FIFO, push and pop together: nothing lost.
        ready0 = 1'b1; ready1 = 1'b1; step(); ready0 = 1'b0; ready1 = 1'b0;
        rw = 1'b0;
        check("pushpop_level0", o_level_w[0], 16);
        check("pushpop_drops0", o_drop_w[0], 4);
        check("pushpop_drops1", o_drop_w[1], 4);
        stop = 1'b1; step(); stop = 1'b0;
        drain();

        // Randomised phases with varying drain rates.
        for (int ph = 0; ph < 20; ph++) begin
            int rp0 = $urandom_range(0, 4);
            int rp1 = $urandom_range(0, 4);
`ifdef RISCV_TRACE_FILTER_EN
            filt_lo = MAW'($urandom_range(0, 40));
            filt_hi = MAW'($urandom_range(0, 63));
`endif
            for (int c = 0; c < 30; c++) begin
                arm    = ($urandom_range(0, 15) == 0);
                stop   = ($urandom_range(0, 39) == 0);
                rw     = ($urandom_range(0, 2) == 0);
                raddr  = RAW'($urandom);
                rdata  = $urandom;
                mw     = ($urandom_range(0, 3) == 0);
                mr     = ($urandom_range(0, 3) == 0);
                maddr  = MAW'($urandom_range(0, 63));
                wdata  = $urandom;
                rddata = $urandom;
                pc     = PC_W'($urandom);
                ready0 = ($urandom_range(0, 3) < rp0);
                ready1 = ($urandom_range(0, 3) < rp1);
                step();
            end
        end
        clear_events();
        filt_lo = '0;
        filt_hi = '1;
        stop = 1'b1; step(); stop = 1'b0;
        drain();

        // Bounded window: continuous events, consumer always ready.
        arm = 1'b1; step(); arm = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1;
        for (int c = 0; c < STOP + 4; c++) begin
            rw = 1'b1; raddr = RAW'(c); rdata = $urandom; pc = PC_W'(c);
            if (o_valid_w[0]) last_ts = f_ts(o_entry_w[0]);
            step();
            if (c == STOP - 2) check("window_not_done", o_done_w[0], 1'b0);
            if (c == STOP - 1) check("window_done", o_done_w[0], 1'b1);
        end
        rw = 1'b0;
        drain();
        check("window_last_ts", last_ts, STOP - 1);

        // Re-arm restarts the timestamp.
        arm = 1'b1; step(); arm = 1'b0;
        rw = 1'b1; step();
        check("rearm_valid", o_valid_w[0], 1'b1);
        check("rearm_ts", f_ts(o_entry_w[0]), 0);
        repeat (6) step();
        rw = 1'b0;
        check("pre_reset_level", o_level_w[0], 7);

        // Asynchronous reset between clock edges.
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check("areset_valid", o_valid_w[0], 1'b0);
        check("areset_level", o_level_w[0], 0);
        check("areset_running", o_run_w[0], 1'b0);
        compare_all();
        #2;
        reset = 1'b1;
        step();

`ifdef RISCV_TRACE_FILTER_EN
        // Address window 16..31 with reads around both edges.
        filt_lo = 9'd16;
        filt_hi = 9'd31;
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int addrs [4] = '{8, 16, 31, 32};
            mr = 1'b1; maddr = MAW'(addrs[i]); rddata = $urandom;
            step();
        end
        mr = 1'b0;
        step();
        check("filt_level", o_level_w[0], 2);
        check("filt_first", o_entry_w[0][MA_LSB +: MAW], 16);
        ready0 = 1'b1; step(); ready0 = 1'b0;
        check("filt_second", o_entry_w[0][MA_LSB +: MAW], 31);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
